pcm_rom_arbiter: RTL and testbench

PCM_ROM_ARBITER -- requirements
Module: pcm_rom_arbiter

---
 rtl/pcm_rom_arbiter_pkg.sv | 28 ++
 rtl/pcm_byte_cache.sv | 53 +++++
 rtl/pcm_rom_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_pcm_rom_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_rom_arbiter_pkg.sv
// Shared sound package: arbiter FSM encoding, timeout defaults and small helpers.
package pcm_rom_arbiter_pkg;

   // Default SDRAM wait timeout in CLK96 cycles
   localparam int unsigned TmoDefault = 255;

   // The wait counter is 8 bits wide and saturates
   localparam int unsigned TmoCntWidth = 8;
   typedef logic [TmoCntWidth-1:0] tmo_cnt_t;

   typedef logic [7:0] pcm_byte_t;

   // Byte returned to a channel when the SDRAM never answers
   localparam pcm_byte_t TmoFillByte = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StWait,
      StDone
   } pcm_state_e;

   // Saturating increment for the wait counter
   function automatic tmo_cnt_t tmo_cnt_inc(input tmo_cnt_t cnt);
      return (cnt == '1) ? cnt : cnt + tmo_cnt_t'(1);
   endfunction

endpackage

// File: rtl/pcm_byte_cache.sv
// One-entry byte cache for a single ADPCM channel: tag compare plus fill port.
module pcm_byte_cache
   import pcm_rom_arbiter_pkg::*;
#(
   parameter int unsigned AW = 21
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [AW-1:0] addr_i,
   input  logic          cs_i,
   input  logic          fill_i,
   input  logic [AW-1:0] fill_tag_i,
   input  logic [7:0]    fill_data_i,
   output logic          hit_o,
   output logic          miss_o,
   output logic [7:0]    dout_o
);

   logic [AW-1:0] tag_q, tag_d;
   pcm_byte_t     data_q, data_d;
   logic          valid_q, valid_d;

   // Next-state: a fill overwrites the whole entry, otherwise hold
   always_comb begin
      tag_d   = tag_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (fill_i) begin
         tag_d   = fill_tag_i;
         data_d  = fill_data_i;
         valid_d = 1'b1;
      end
   end

   // Entry storage with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Purely combinational so an address change drops the hit in the same cycle
   assign hit_o  = cs_i & valid_q & (tag_q == addr_i);
   assign miss_o = cs_i & ~hit_o;
   assign dout_o = data_q;

endmodule

// File: rtl/pcm_rom_arbiter.sv
// Arbitrates two ADPCM channel byte fetches onto one shared SDRAM slot, with a
// one-entry cache per channel and a saturating wait timeout.
module pcm_rom_arbiter
   import pcm_rom_arbiter_pkg::*;
#(
   parameter int unsigned AW  = 21,
   parameter int unsigned TMO = TmoDefault
) (
   input  logic          CLK96,
   input  logic          RESET96_N,
   input  logic [AW-1:0] A0_ADDR,
   input  logic [AW-1:0] A1_ADDR,
   input  logic          A0_CS,
   input  logic          A1_CS,
   output logic [7:0]    A0_DOUT,
   output logic [7:0]    A1_DOUT,
   output logic          A0_OK,
   output logic          A1_OK,
   output logic [AW-1:0] SD_ADDR,
   output logic          SD_CS,
   input  logic          SD_OK,
   input  logic [7:0]    SD_DOUT,
   output logic          TMO_ERR
);

   // Values above the counter range clamp to the saturation point
   localparam tmo_cnt_t TmoLimit = (TMO > 255) ? tmo_cnt_t'(255) : TMO[TmoCntWidth-1:0];

   pcm_state_e    state_q, state_d;
   logic          gnt_q, gnt_d;      // channel being served
   logic          prio_q, prio_d;    // winner when both channels miss
   logic [AW-1:0] sd_addr_q, sd_addr_d;
   logic          sd_cs_q, sd_cs_d;
   tmo_cnt_t      tmo_cnt_q, tmo_cnt_d;
   logic          tmo_err_q, tmo_err_d;

   logic          miss0, miss1;
   logic          fill, fill0, fill1;
   pcm_byte_t     fill_data;
   tmo_cnt_t      tmo_cnt_nxt;
   logic          tmo_hit;

   pcm_byte_cache #(
      .AW(AW)
   ) u_cache0 (
      .clk_i      (CLK96),
      .rst_ni     (RESET96_N),
      .addr_i     (A0_ADDR),
      .cs_i       (A0_CS),
      .fill_i     (fill0),
      .fill_tag_i (sd_addr_q),
      .fill_data_i(fill_data),
      .hit_o      (A0_OK),
      .miss_o     (miss0),
      .dout_o     (A0_DOUT)
   );

   pcm_byte_cache #(
      .AW(AW)
   ) u_cache1 (
      .clk_i      (CLK96),
      .rst_ni     (RESET96_N),
      .addr_i     (A1_ADDR),
      .cs_i       (A1_CS),
      .fill_i     (fill1),
      .fill_tag_i (sd_addr_q),
      .fill_data_i(fill_data),
      .hit_o      (A1_OK),
      .miss_o     (miss1),
      .dout_o     (A1_DOUT)
   );

   // The timeout fires on the wait cycle that would bring the count to TMO
   assign tmo_cnt_nxt = tmo_cnt_inc(tmo_cnt_q);
   assign tmo_hit     = (tmo_cnt_nxt >= TmoLimit);

   // State register
   always_ff @(posedge CLK96) begin
      if (!RESET96_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (miss0 || miss1) begin
               state_d = StSettle;
            end
         end
         StSettle: begin
            state_d = StWait;
         end
         StWait: begin
            if (SD_OK || tmo_hit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output and datapath logic: grant, SDRAM request, fill strobes, timeout
   always_comb begin
      gnt_d     = gnt_q;
      prio_d    = prio_q;
      sd_addr_d = sd_addr_q;
      sd_cs_d   = sd_cs_q;
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = 1'b0;
      fill      = 1'b0;
      fill_data = SD_DOUT;
      unique case (state_q)
         StIdle: begin
            if (miss0 || miss1) begin
               // A lone miss wins regardless of the pointer
               gnt_d     = (miss0 && miss1) ? prio_q : miss1;
               sd_addr_d = gnt_d ? A1_ADDR : A0_ADDR;
               sd_cs_d   = 1'b1;
               tmo_cnt_d = '0;
            end
         end
         StSettle: begin
            // SD_OK is not trusted in the first request cycle
            sd_cs_d = 1'b1;
         end
         StWait: begin
            if (SD_OK) begin
               fill    = 1'b1;
               sd_cs_d = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_nxt;
               if (tmo_hit) begin
                  fill      = 1'b1;
                  fill_data = TmoFillByte;
                  tmo_err_d = 1'b1;
                  sd_cs_d   = 1'b0;
               end
            end
         end
         StDone: begin
            prio_d = ~gnt_q;
         end
         default: begin
            sd_cs_d = 1'b0;
         end
      endcase
   end

   // Fill always uses the latched tag, so a mid-fetch address change misses
   assign fill0 = fill & ~gnt_q;
   assign fill1 = fill & gnt_q;

   // Datapath registers
   always_ff @(posedge CLK96) begin
      if (!RESET96_N) begin
         gnt_q     <= 1'b0;
         prio_q    <= 1'b0;
         sd_addr_q <= '0;
         sd_cs_q   <= 1'b0;
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         prio_q    <= prio_d;
         sd_addr_q <= sd_addr_d;
         sd_cs_q   <= sd_cs_d;
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign SD_ADDR = sd_addr_q;
   assign SD_CS   = sd_cs_q;
   assign TMO_ERR = tmo_err_q;

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// Bench for pcm_rom_arbiter: directed stimulus pushes expected SDRAM fetches and
// cache fills into queues; a monitor pops and compares when the DUT shows them.
module tb_pcm_rom_arbiter;

   localparam int unsigned AW = 21;

   logic          CLK96 = 1'b0;
   logic          RESET96_N;
   logic [AW-1:0] A0_ADDR, A1_ADDR;
   logic          A0_CS, A1_CS;
   logic [7:0]    A0_DOUT, A1_DOUT;
   logic          A0_OK, A1_OK;
   logic [AW-1:0] SD_ADDR;
   logic          SD_CS;
   logic          SD_OK;
   logic [7:0]    SD_DOUT;
   logic          TMO_ERR;

   always #5 CLK96 = ~CLK96;

   pcm_rom_arbiter #(
      .AW (AW),
      .TMO(255)
   ) dut (
      .CLK96    (CLK96),
      .RESET96_N(RESET96_N),
      .A0_ADDR  (A0_ADDR),
      .A1_ADDR  (A1_ADDR),
      .A0_CS    (A0_CS),
      .A1_CS    (A1_CS),
      .A0_DOUT  (A0_DOUT),
      .A1_DOUT  (A1_DOUT),
      .A0_OK    (A0_OK),
      .A1_OK    (A1_OK),
      .SD_ADDR  (SD_ADDR),
      .SD_CS    (SD_CS),
      .SD_OK    (SD_OK),
      .SD_DOUT  (SD_DOUT),
      .TMO_ERR  (TMO_ERR)
   );

   typedef struct packed {
      logic       chan;
      logic [7:0] data;
   } fill_t;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [AW-1:0] exp_fetch[$];
   fill_t         exp_fill[$];

   // SDRAM model controls
   int            rsp_lat = 1;
   logic          man_ok = 1'b0;
   logic [7:0]    man_data = 8'h00;

   // Monitor state
   logic          m_cs_prev = 1'b0;
   logic          m_ok0_prev = 1'b0;
   logic          m_ok1_prev = 1'b0;
   logic [AW-1:0] m_addr;
   fill_t         m_fill;

   // Observation results
   int            cs_hi, ok0_hi, err_hi, err_first;

   function automatic logic [7:0] rsp_byte(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK96);
   endtask

   task automatic observe(input int n, output int o_cs, output int o_ok0, output int o_err,
                          output int o_first);
      o_cs = 0;
      o_ok0 = 0;
      o_err = 0;
      o_first = 0;
      for (int i = 1; i <= n; i++) begin
         @(negedge CLK96);
         if (SD_CS) o_cs++;
         if (A0_OK) o_ok0++;
         if (TMO_ERR) begin
            o_err++;
            if (o_first == 0) o_first = i;
         end
      end
   endtask

   task automatic mon_fill(input logic chan, input logic [7:0] dout);
      if (exp_fill.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_fill: chan %0d data 0x%0h, none expected", chan, dout);
      end else begin
         m_fill = exp_fill.pop_front();
         chk("fill_chan", 32'(chan), 32'(m_fill.chan));
         chk("fill_data", 32'(dout), 32'(m_fill.data));
      end
   endtask

   // SDRAM responder: answers rsp_lat cycles after SD_CS rises, or forced by man_ok
   initial begin : responder
      int age;
      age = 0;
      SD_OK = 1'b0;
      SD_DOUT = 8'h00;
      forever begin
         @(negedge CLK96);
         if (man_ok) begin
            SD_OK = 1'b1;
            SD_DOUT = man_data;
            age = 0;
         end else if (SD_CS) begin
            if (age == rsp_lat) begin
               SD_OK = 1'b1;
               SD_DOUT = rsp_byte(SD_ADDR);
            end else begin
               SD_OK = 1'b0;
            end
            age++;
         end else begin
            SD_OK = 1'b0;
            age = 0;
         end
      end
   end

   // Monitor: fetch start on SD_CS rise, fill completion on Ax_OK rise
   initial begin : monitor
      forever begin
         @(posedge CLK96);
         #1;
         if (SD_CS && !m_cs_prev) begin
            if (exp_fetch.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_fetch: SD_ADDR 0x%0h, none expected", SD_ADDR);
            end else begin
               m_addr = exp_fetch.pop_front();
               chk("fetch_addr", 32'(SD_ADDR), 32'(m_addr));
            end
         end
         if (A0_OK && !m_ok0_prev) mon_fill(1'b0, A0_DOUT);
         if (A1_OK && !m_ok1_prev) mon_fill(1'b1, A1_DOUT);
         m_cs_prev = SD_CS;
         m_ok0_prev = A0_OK;
         m_ok1_prev = A1_OK;
      end
   end

   initial begin : stimulus
      // Reset with both channels requesting address 0: a stale valid bit would hit
      RESET96_N = 1'b0;
      A0_ADDR = '0;
      A1_ADDR = '0;
      A0_CS = 1'b1;
      A1_CS = 1'b1;
      step(3);
      chk("rst_sd_cs", 32'(SD_CS), 32'h0);
      chk("rst_sd_addr", 32'(SD_ADDR), 32'h0);
      chk("rst_tmo_err", 32'(TMO_ERR), 32'h0);
      chk("rst_a0_ok", 32'(A0_OK), 32'h0);
      chk("rst_a1_ok", 32'(A1_OK), 32'h0);
      chk("rst_a0_dout", 32'(A0_DOUT), 32'h0);
      chk("rst_a1_dout", 32'(A1_DOUT), 32'h0);
      RESET96_N = 1'b1;
      A0_CS = 1'b0;
      A1_CS = 1'b0;
      step(1);

      // Simultaneous miss with pointer at reset value: channel 0 then channel 1
      exp_fetch.push_back(21'h00010);
      exp_fetch.push_back(21'h100020);
      exp_fill.push_back('{1'b0, 8'h4A});
      exp_fill.push_back('{1'b1, 8'h7A});
      rsp_lat = 1;
      A0_ADDR = 21'h00010;
      A1_ADDR = 21'h100020;
      A0_CS = 1'b1;
      A1_CS = 1'b1;
      step(12);
      chk("dual1_a0_ok", 32'(A0_OK), 32'h1);
      chk("dual1_a0_dout", 32'(A0_DOUT), 32'h4A);
      chk("dual1_a1_ok", 32'(A1_OK), 32'h1);
      chk("dual1_a1_dout", 32'(A1_DOUT), 32'h7A);

      // Channel 0 fetch with SD_OK three cycles after SD_CS: SD_CS high 4 cycles
      exp_fetch.push_back(21'h01234);
      exp_fill.push_back('{1'b0, 8'h7C});
      rsp_lat = 3;
      A0_ADDR = 21'h01234;
      observe(10, cs_hi, ok0_hi, err_hi, err_first);
      chk("lat3_cs_cycles", 32'(cs_hi), 32'd4);
      chk("lat3_a0_ok", 32'(A0_OK), 32'h1);
      chk("lat3_a0_dout", 32'(A0_DOUT), 32'h7C);
      chk("lat3_a1_still_hit", 32'(A1_OK), 32'h1);

      // Last served was channel 0, so the next simultaneous miss goes to channel 1
      exp_fetch.push_back(21'h100040);
      exp_fetch.push_back(21'h00030);
      exp_fill.push_back('{1'b1, 8'h1A});
      exp_fill.push_back('{1'b0, 8'h6A});
      rsp_lat = 1;
      A0_ADDR = 21'h00030;
      A1_ADDR = 21'h100040;
      step(12);
      chk("dual2_a0_dout", 32'(A0_DOUT), 32'h6A);
      chk("dual2_a1_dout", 32'(A1_DOUT), 32'h1A);

      // Address change during WAIT: old tag filled, OK stays low, new address refetched
      A1_CS = 1'b0;
      exp_fetch.push_back(21'h00100);
      exp_fetch.push_back(21'h00101);
      exp_fill.push_back('{1'b0, 8'h5A});
      rsp_lat = 5;
      A0_ADDR = 21'h00100;
      step(3);
      A0_ADDR = 21'h00101;
      step(2);
      chk("chg_sd_addr_stable", 32'(SD_ADDR), 32'h00100);
      chk("chg_sd_cs_held", 32'(SD_CS), 32'h1);
      step(2);
      chk("chg_done_ok_low", 32'(A0_OK), 32'h0);
      chk("chg_old_fill", 32'(A0_DOUT), 32'h5B);
      chk("chg_done_cs_low", 32'(SD_CS), 32'h0);
      step(12);
      chk("chg_refetch_ok", 32'(A0_OK), 32'h1);
      chk("chg_refetch_dout", 32'(A0_DOUT), 32'h5A);

      // SDRAM silent for 300 cycles: timeout after 255 wait cycles fills 0xFF
      exp_fetch.push_back(21'h00300);
      exp_fill.push_back('{1'b0, 8'hFF});
      rsp_lat = 1000;
      A0_ADDR = 21'h00300;
      observe(300, cs_hi, ok0_hi, err_hi, err_first);
      chk("tmo_cs_cycles", 32'(cs_hi), 32'd256);
      chk("tmo_err_pulses", 32'(err_hi), 32'd1);
      chk("tmo_err_cycle", 32'(err_first), 32'd257);
      chk("tmo_a0_ok", 32'(A0_OK), 32'h1);
      chk("tmo_a0_dout", 32'(A0_DOUT), 32'hFF);

      // Repeated hit: no SDRAM traffic, OK held
      exp_fetch.push_back(21'h00200);
      exp_fill.push_back('{1'b0, 8'h58});
      rsp_lat = 2;
      A0_ADDR = 21'h00200;
      step(10);
      observe(20, cs_hi, ok0_hi, err_hi, err_first);
      chk("hit_no_sd_cs", 32'(cs_hi), 32'd0);
      chk("hit_ok_held", 32'(ok0_hi), 32'd20);
      chk("hit_a0_dout", 32'(A0_DOUT), 32'h58);

      // Reset for one cycle during WAIT abandons the fetch; late SD_OK ignored
      exp_fetch.push_back(21'h00400);
      rsp_lat = 1000;
      A0_ADDR = 21'h00400;
      step(3);
      RESET96_N = 1'b0;
      A0_CS = 1'b0;
      step(1);
      RESET96_N = 1'b1;
      chk("mid_rst_sd_cs", 32'(SD_CS), 32'h0);
      chk("mid_rst_sd_addr", 32'(SD_ADDR), 32'h0);
      chk("mid_rst_a0_ok", 32'(A0_OK), 32'h0);
      chk("mid_rst_a1_ok", 32'(A1_OK), 32'h0);
      chk("mid_rst_a0_dout", 32'(A0_DOUT), 32'h0);
      chk("mid_rst_a1_dout", 32'(A1_DOUT), 32'h0);
      man_data = 8'h77;
      man_ok = 1'b1;
      step(2);
      man_ok = 1'b0;
      step(2);
      chk("late_ok_a0_dout", 32'(A0_DOUT), 32'h0);
      chk("late_ok_a1_dout", 32'(A1_DOUT), 32'h0);
      chk("late_ok_sd_cs", 32'(SD_CS), 32'h0);

      // Normal service resumes after the abandoned fetch
      exp_fetch.push_back(21'h00400);
      exp_fill.push_back('{1'b0, 8'h5E});
      rsp_lat = 1;
      A0_CS = 1'b1;
      step(10);
      chk("post_rst_a0_ok", 32'(A0_OK), 32'h1);
      chk("post_rst_a0_dout", 32'(A0_DOUT), 32'h5E);

      step(2);
      chk("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
      chk("fill_queue_drained", 32'(exp_fill.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
